// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline: control bundle, register indices, datapath width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

   localparam int DATA_W  = 64;
   localparam int REG_W   = 5;
   localparam int ALUOP_W = 4;

   // XZR reads as zero and discards writes, so it can never carry a dependency
   localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

   typedef struct packed {
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
      logic               alusrc;
      logic               branch;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   // A bubble has every control bit cleared: it writes nothing and touches no memory
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: LDUR in EX whose destination is read by the ID instruction.
// Latency: 0 cycles (pure combinational).
// Backpressure: produces the stall request only; the caller applies it to PC, IF/ID and ID/EX.
module load_use_detect #(
   parameter int REG_W  = 5,
   parameter int ZR_IDX = 31
) (
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   output logic             load_use_stall
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZR_IDX);

   logic hit_rs1;
   logic hit_rs2;

   // A source only counts if the instruction really reads it; a decoded but unused field may alias ex_rd
   assign hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
   assign hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);

   assign load_use_stall = ex_valid && ex_memread && id_valid && (ex_rd != ZR) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, global hold and branch flush (optional stall counter: IDEX_PERF_CNT_EN).
// Latency: 1 cycle from id_* to ex_*; hazard and pc_write/ifid_write are combinational.
// Backpressure: hold freezes all contents; a load-use hazard drops pc_write/ifid_write for one cycle and loads a bubble.
module idex_hazard_reg #(
   parameter int DATA_W  = 64,
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 4,
   parameter int ZR_IDX  = 31
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [REG_W-1:0]   id_rs1,
   input  logic [REG_W-1:0]   id_rs2,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [DATA_W-1:0]  id_rd1,
   input  logic [DATA_W-1:0]  id_rd2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [DATA_W-1:0]  id_pc,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               id_alusrc,
   input  logic               id_branch,
   input  logic [ALUOP_W-1:0] id_aluop,
   output logic               ex_valid,
   output logic [REG_W-1:0]   ex_rs1,
   output logic [REG_W-1:0]   ex_rs2,
   output logic [REG_W-1:0]   ex_rd,
   output logic [DATA_W-1:0]  ex_rd1,
   output logic [DATA_W-1:0]  ex_rd2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [DATA_W-1:0]  ex_pc,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_memtoreg,
   output logic               ex_alusrc,
   output logic               ex_branch,
   output logic [ALUOP_W-1:0] ex_aluop,
`ifdef IDEX_PERF_CNT_EN
   input  logic               cnt_clr,
   output logic [31:0]        stall_cnt,
`endif
   output logic               pc_write,
   output logic               ifid_write,
   output logic               load_use_stall
);

   import cpu_pkg::*;

   localparam logic [REG_W-1:0] ZR = REG_W'(ZR_IDX);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  load_bubble;

   // An invalid ID slot must not carry live control into EX, whatever the decoder left on the wires
   assign id_ctrl = id_valid ? '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                                 memtoreg: id_memtoreg, alusrc: id_alusrc, branch: id_branch,
                                 aluop: id_aluop}
                             : CTRL_BUBBLE;

   load_use_detect #(
      .REG_W  (REG_W),
      .ZR_IDX (ZR_IDX)
   ) u_detect (
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .ex_valid       (ex_valid),
      .ex_memread     (ex_ctrl.memread),
      .ex_rd          (ex_rd),
      .load_use_stall (load_use_stall)
   );

   // Front end freezes on a hazard or a global hold; a flush redirect is handled by the front end itself
   assign pc_write   = !(load_use_stall || hold);
   assign ifid_write = !(load_use_stall || hold);

   // Flush beats hold beats the hazard bubble
   assign load_bubble = flush || (!hold && load_use_stall);

   // ID/EX state: reset and bubbles park register indices on XZR so nothing downstream forwards from them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_BUBBLE;
         ex_rs1   <= ZR;
         ex_rs2   <= ZR;
         ex_rd    <= ZR;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_pc    <= '0;
      end else if (load_bubble) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_BUBBLE;
         ex_rs1   <= ZR;
         ex_rs2   <= ZR;
         ex_rd    <= ZR;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_pc    <= '0;
      end else if (!hold) begin
         ex_valid <= id_valid;
         ex_ctrl  <= id_ctrl;
         ex_rs1   <= id_rs1;
         ex_rs2   <= id_rs2;
         ex_rd    <= id_rd;
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_pc    <= id_pc;
      end
   end

   assign ex_regwrite = ex_ctrl.regwrite;
   assign ex_memread  = ex_ctrl.memread;
   assign ex_memwrite = ex_ctrl.memwrite;
   assign ex_memtoreg = ex_ctrl.memtoreg;
   assign ex_alusrc   = ex_ctrl.alusrc;
   assign ex_branch   = ex_ctrl.branch;
   assign ex_aluop    = ex_ctrl.aluop;

`ifdef IDEX_PERF_CNT_EN
   // Count only bubbles the hazard actually inserted; held or flushed cycles are not load-use losses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (load_use_stall && !hold && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_idex_hazard_reg.sv
module tb_idex_hazard_reg;

   logic        clk;
   logic        rst_n;
   logic        hold;
   logic        flush;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2;
   logic [63:0] id_rd1, id_rd2, id_imm, id_pc;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch;
   logic [3:0]  id_aluop;
   logic        ex_valid;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [63:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
   logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch;
   logic [3:0]  ex_aluop;
   logic        pc_write, ifid_write, load_use_stall;
`ifdef IDEX_PERF_CNT_EN
   logic        cnt_clr;
   logic [31:0] stall_cnt;
   logic [31:0] exp_cnt;
`endif

   idex_hazard_reg dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hold           (hold),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .id_rd1         (id_rd1),
      .id_rd2         (id_rd2),
      .id_imm         (id_imm),
      .id_pc          (id_pc),
      .id_regwrite    (id_regwrite),
      .id_memread     (id_memread),
      .id_memwrite    (id_memwrite),
      .id_memtoreg    (id_memtoreg),
      .id_alusrc      (id_alusrc),
      .id_branch      (id_branch),
      .id_aluop       (id_aluop),
      .ex_valid       (ex_valid),
      .ex_rs1         (ex_rs1),
      .ex_rs2         (ex_rs2),
      .ex_rd          (ex_rd),
      .ex_rd1         (ex_rd1),
      .ex_rd2         (ex_rd2),
      .ex_imm         (ex_imm),
      .ex_pc          (ex_pc),
      .ex_regwrite    (ex_regwrite),
      .ex_memread     (ex_memread),
      .ex_memwrite    (ex_memwrite),
      .ex_memtoreg    (ex_memtoreg),
      .ex_alusrc      (ex_alusrc),
      .ex_branch      (ex_branch),
      .ex_aluop       (ex_aluop),
`ifdef IDEX_PERF_CNT_EN
      .cnt_clr        (cnt_clr),
      .stall_cnt      (stall_cnt),
`endif
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .load_use_stall (load_use_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        pcw;
      logic        v;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rw;
      logic        mr;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Stimulus: drive one ID instruction; control pattern follows the instruction kind
   task automatic ins(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic u1, input logic u2, input logic mr,
                      input logic [63:0] d1, input logic [63:0] d2);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      id_rd1      = d1;
      id_rd2      = d2;
      id_imm      = d1 ^ 64'hF0;
      id_pc       = {57'd0, rd, 2'b00};
      id_regwrite = 1'b1;
      id_memread  = mr;
      id_memwrite = 1'b0;
      id_memtoreg = mr;
      id_alusrc   = mr;
      id_branch   = 1'b0;
      id_aluop    = mr ? 4'h2 : 4'h8;
   endtask

   // Expected: combinational outputs this cycle, EX contents after the next rising edge
   task automatic push(input logic st, input logic pcw, input logic v, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic rw, input logic mr,
                       input logic [63:0] d1, input logic [63:0] d2);
      exp_t e;
      e.stall = st;
      e.pcw   = pcw;
      e.v     = v;
      e.rd    = rd;
      e.rs1   = rs1;
      e.rs2   = rs2;
      e.rw    = rw;
      e.mr    = mr;
      e.d1    = d1;
      e.d2    = d2;
`ifdef IDEX_PERF_CNT_EN
      if (!rst_n)                                      exp_cnt = 32'd0;
      else if (cnt_clr)                                exp_cnt = 32'd0;
      else if (st && !hold && !flush && exp_cnt != '1) exp_cnt = exp_cnt + 32'd1;
      e.cnt = exp_cnt;
`else
      e.cnt = 32'd0;
`endif
      sb_q.push_back(e);
   endtask

   task automatic bub(input logic st, input logic pcw);
      push(st, pcw, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   // Monitor: combinational checks mid-cycle, registered checks just after the following edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("load_use_stall", load_use_stall, e.stall);
            chk("pc_write", pc_write, e.pcw);
            chk("ifid_write", ifid_write, e.pcw);
            @(posedge clk);
            #1;
            chk("ex_valid", ex_valid, e.v);
            chk("ex_rd", ex_rd, e.rd);
            chk("ex_rs1", ex_rs1, e.rs1);
            chk("ex_rs2", ex_rs2, e.rs2);
            chk("ex_regwrite", ex_regwrite, e.rw);
            chk("ex_memread", ex_memread, e.mr);
            chk("ex_rd1", ex_rd1, e.d1);
            chk("ex_rd2", ex_rd2, e.d2);
`ifdef IDEX_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, 64'(e.cnt));
`endif
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      hold  = 1'b0;
      flush = 1'b0;
`ifdef IDEX_PERF_CNT_EN
      cnt_clr = 1'b0;
      exp_cnt = 32'd0;
`endif
      ins(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);

      // reset held while ID toggles
      sync(); ins(1, 1, 2, 9, 1, 1, 0, 64'h11, 64'h22); bub(0, 1);
      sync(); ins(1, 4, 5, 6, 1, 1, 1, 64'h33, 64'h44); bub(0, 1);
      // ADD X3,X1,X2
      sync(); rst_n = 1'b1; ins(1, 1, 2, 3, 1, 1, 0, 64'd5, 64'd7);
      push(0, 1, 1, 3, 1, 2, 1, 0, 64'd5, 64'd7);
      // LDUR X2,[X1] then dependent ADD X4,X2,X5
      sync(); ins(1, 1, 0, 2, 1, 0, 1, 64'h10, 64'd0); push(0, 1, 1, 2, 1, 0, 1, 1, 64'h10, 64'd0);
      sync(); ins(1, 2, 5, 4, 1, 1, 0, 64'hAA, 64'hBB); bub(1, 0);
      sync(); push(0, 1, 1, 4, 2, 5, 1, 0, 64'hAA, 64'hBB);
      // LDUR XZR followed by a reader of X31: no hazard
      sync(); ins(1, 1, 0, 31, 1, 0, 1, 64'h20, 64'd0); push(0, 1, 1, 31, 1, 0, 1, 1, 64'h20, 64'd0);
      sync(); ins(1, 31, 31, 7, 1, 1, 0, 64'd0, 64'h33); push(0, 1, 1, 7, 31, 31, 1, 0, 64'd0, 64'h33);
      // LDUR X6 followed by an instruction whose unused rs2 field is 6
      sync(); ins(1, 1, 0, 6, 1, 0, 1, 64'h40, 64'd0); push(0, 1, 1, 6, 1, 0, 1, 1, 64'h40, 64'd0);
      sync(); ins(1, 1, 6, 8, 1, 0, 0, 64'h50, 64'h66); push(0, 1, 1, 8, 1, 6, 1, 0, 64'h50, 64'h66);
      // hold for three cycles with changing ID
      for (int i = 0; i < 3; i++) begin
         sync(); hold = 1'b1;
         ins(1, 6, 6, 5'(10 + i), 1, 1, 1, 64'(32'h60 + i), 64'(32'h70 + i));
         push(0, 0, 1, 8, 1, 6, 1, 0, 64'h50, 64'h66);
      end
      sync(); hold = 1'b0; ins(1, 3, 4, 13, 1, 1, 0, 64'h77, 64'h88);
      push(0, 1, 1, 13, 3, 4, 1, 0, 64'h77, 64'h88);
      // flush together with hold and a live load-use hazard
      sync(); ins(1, 3, 0, 9, 1, 0, 1, 64'h90, 64'd0); push(0, 1, 1, 9, 3, 0, 1, 1, 64'h90, 64'd0);
      sync(); hold = 1'b1; flush = 1'b1; ins(1, 9, 9, 10, 1, 1, 0, 64'd1, 64'd2); bub(1, 0);
      // invalid ID slot: indices and data load, control stays zero
      sync(); hold = 1'b0; flush = 1'b0; ins(0, 4, 7, 5, 1, 1, 0, 64'h12, 64'h34);
      push(0, 1, 0, 5, 4, 7, 0, 0, 64'h12, 64'h34);
      // flush alone squashes a valid instruction
      sync(); flush = 1'b1; ins(1, 1, 2, 11, 1, 1, 0, 64'd3, 64'd4); bub(0, 1);
      // LDUR X1; LDUR X2,[X1]; ADD X4,X2,X2 -- one stall each
      sync(); flush = 1'b0; ins(1, 3, 0, 1, 1, 0, 1, 64'hA0, 64'd0); push(0, 1, 1, 1, 3, 0, 1, 1, 64'hA0, 64'd0);
      sync(); ins(1, 1, 0, 2, 1, 0, 1, 64'hB0, 64'd0); bub(1, 0);
      sync(); push(0, 1, 1, 2, 1, 0, 1, 1, 64'hB0, 64'd0);
      sync(); ins(1, 2, 2, 4, 1, 1, 0, 64'hC0, 64'hC1); bub(1, 0);
      sync(); push(0, 1, 1, 4, 2, 2, 1, 0, 64'hC0, 64'hC1);
      // reset asserted while a hazard is present, then released
      sync(); ins(1, 3, 0, 5, 1, 0, 1, 64'hD0, 64'd0); push(0, 1, 1, 5, 3, 0, 1, 1, 64'hD0, 64'd0);
      sync(); rst_n = 1'b0; ins(1, 5, 1, 6, 1, 1, 0, 64'hE0, 64'hE1); bub(0, 1);
      sync(); rst_n = 1'b1; push(0, 1, 1, 6, 5, 1, 1, 0, 64'hE0, 64'hE1);
      // four separate load-use events; clear pulsed with the last
      for (int k = 0; k < 4; k++) begin
         sync(); ins(1, 3, 0, 7, 1, 0, 1, 64'hF0, 64'd0); push(0, 1, 1, 7, 3, 0, 1, 1, 64'hF0, 64'd0);
         sync();
`ifdef IDEX_PERF_CNT_EN
         cnt_clr = (k == 3);
`endif
         ins(1, 7, 1, 8, 1, 1, 0, 64'hF1, 64'hF2); bub(1, 0);
         sync();
`ifdef IDEX_PERF_CNT_EN
         cnt_clr = 1'b0;
`endif
         push(0, 1, 1, 8, 7, 1, 1, 0, 64'hF1, 64'hF2);
      end

      sync(); sync(); sync();
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idex_hazard_reg.md
Name: idex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage LEGv8 CPU, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control from ID; presents them to EX, where the forwarding unit reads ex_rs1/ex_rs2.
- Detects LDUR-to-dependent-instruction hazards and inserts a one-cycle bubble while freezing PC and IF/ID.
- Also supports a global hold (memory stall) and flush (taken branch).

Parameters:
- DATA_W, 64, width of operand/immediate/PC datapath.
- REG_W, 5, register index width.
- ALUOP_W, 4, ALU operation code width.
- ZR_IDX, 31, index of XZR; never a hazard source.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global stall; freeze all ID/EX contents.
- flush  in  1  squash the instruction entering EX (branch taken in MEM).
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_W each  decoded register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads that source.
- id_rd1, id_rd2, id_imm, id_pc  in  DATA_W each  register-file data, sign-extended immediate, PC.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  in  1 each  control bits.
- id_aluop  in  ALUOP_W  ALU control.
- ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_aluop  out  matching widths  registered ID/EX contents.
- pc_write  out  1  0 = hold PC.
- ifid_write  out  1  0 = hold IF/ID.
- load_use_stall  out  1  hazard detected this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - all ex_* control bits, ex_valid and all data fields are 0.
  - ex_rd, ex_rs1 and ex_rs2 are ZR_IDX, so reset state never matches a hazard or forward.
- Hazard (combinational):
  - load_use_stall = ex_valid & ex_memread & id_valid & (ex_rd != ZR_IDX) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Control outputs (combinational):
  - pc_write = ifid_write = !(load_use_stall | hold).
- Register update, per rising edge, priority order:
  1. flush=1: load bubble (ex_valid=0, all control bits 0, ex_rd=ZR_IDX). Flush wins over hold and stall.
  2. hold=1: retain all contents.
  3. load_use_stall=1: load bubble. The ID instruction stays in IF/ID and re-presents next cycle.
  4. Otherwise: load all id_* fields. ex_valid=id_valid. If id_valid=0, control bits load as 0.
- Latency: 1 cycle from ID to EX outputs.
- A stall lasts exactly one cycle. The bubble clears ex_memread, so the repeated ID instruction proceeds; the forwarding unit then supplies the value via the MEM/WB path.
- Data fields of a bubble: don't-care, but driven 0.
- Consecutive dependent loads (LDUR X1; LDUR X2,[X1]) stall once each.
- flush and load_use_stall together: bubble. pc_write/ifid_write still follow the stall; the front end handles redirect.
- Reset asserted mid-stall: outputs return to reset values immediately. The first post-reset cycle has no stall.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32-bit) and input cnt_clr.
  - stall_cnt increments on each cycle with load_use_stall & !hold & !flush, and saturates at 0xFFFFFFFF.
  - cnt_clr zeros it synchronously, with priority over increment. Async reset clears it.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - typedef ctrl_t: packed struct of regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop.
  - constants XZR_IDX=5'd31, DATA_W, CTRL_BUBBLE (all-zero ctrl_t).
- Sub-module load_use_detect: pure combinational hazard equation, reusable by a future dual-issue front end. The register and priority logic stay in the top module.

Test Plan:
- Reset: rst_n=0 while inputs toggle -> ex_valid=0, ex_rd=31, pc_write=1. After release, ADD X3,X1,X2 with id_rd1=5, id_rd2=7 -> next cycle ex_rd1=5, ex_rd2=7, ex_rd=3, ex_regwrite=1.
- Load-use: EX holds LDUR X2 (ex_memread=1, ex_rd=2); ID holds ADD X4,X2,X5 -> load_use_stall=1, pc_write=0, ifid_write=0. Next cycle ex_valid=0 and ex_memread=0. The cycle after, ex_rd=4 and ex_rs1=2.
- XZR / unused source: LDUR XZR in EX with ID reading X31 -> no stall. LDUR X6 in EX with ID id_use_rs2=0 and id_rs2=6 -> no stall.
- hold: hold=1 for 3 cycles with changing id_* -> ex_* frozen, pc_write=0. When hold drops, ID contents load in 1 cycle.
- flush priority: flush=1, hold=1 and load_use_stall=1 simultaneously -> next cycle ex_valid=0, ex_regwrite=0, ex_rd=31.
- With IDEX_PERF_CNT_EN: 3 separate load-use events -> stall_cnt=3. Pulse cnt_clr together with a 4th event -> stall_cnt=0.
